// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register-file geometry, index type and
// the popcount helper used by the register scoreboard.
package riscv_pkg;

    localparam int REGISTER_COUNT       = 32;
    localparam int REGISTER_INDEX_WIDTH = $clog2(REGISTER_COUNT);
    localparam int BUSY_COUNT_WIDTH     = $clog2(REGISTER_COUNT + 1);

    typedef logic [REGISTER_INDEX_WIDTH-1:0] reg_idx_t;

    localparam reg_idx_t X0 = '0;

    function automatic logic [BUSY_COUNT_WIDTH-1:0] popcount(input logic [REGISTER_COUNT-1:0] v);
        logic [BUSY_COUNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < REGISTER_COUNT; k++) begin
            cnt = cnt + BUSY_COUNT_WIDTH'(v[k]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, the
// WAW issue check, per-read-port ready lookups and a registered busy count.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter int BYPASS    = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_READ*REGISTER_INDEX_WIDTH-1:0]  rs_addr,
    output logic [NUM_READ-1:0]                      rs_ready,
    input  logic [NUM_WRITE-1:0]                     wb_wen,
    input  logic [NUM_WRITE*REGISTER_INDEX_WIDTH-1:0] wb_addr,
    input  logic                                     issue_valid,
    input  reg_idx_t                                 issue_rd,
    output logic                                     issue_ready,
    output logic [BUSY_COUNT_WIDTH-1:0]              busy_count
);

    localparam int IW = REGISTER_INDEX_WIDTH;

    logic [REGISTER_COUNT-1:0] busy;
    logic [REGISTER_COUNT-1:0] busy_next;
    logic [REGISTER_COUNT-1:0] wr_hit;
    logic                      issue_fire;
    reg_idx_t                  ra;

    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (wb_wen[j] && wb_addr[j*IW +: IW] != X0) begin
                wr_hit[wb_addr[j*IW +: IW]] = 1'b1;
            end
        end
    end

    // Issue handshake: issue_ready is computed without looking at issue_valid;
    // the issue is accepted only in a cycle where both are high at posedge.
    // A write landing on issue_rd this cycle resolves the WAW hazard early.
    assign issue_ready = !(busy[issue_rd] && !wr_hit[issue_rd]);
    assign issue_fire  = issue_valid && issue_ready && (issue_rd != X0);

    // The new producer owns the register, so its set overrides the write clear.
    always_comb begin
        busy_next = busy & ~wr_hit;
        if (issue_fire) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= popcount(busy_next);
        end
    end

    always_comb begin
        rs_ready = '0;
        ra       = X0;
        for (int i = 0; i < NUM_READ; i++) begin
            ra          = rs_addr[i*IW +: IW];
            rs_ready[i] = !busy[ra] || ((BYPASS != 0) && wr_hit[ra]);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port RISC-V integer register file: x0 hard-wired to zero, highest
// write port wins on address collisions, optional same-cycle read bypass.
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter int BYPASS    = 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_READ*REGISTER_INDEX_WIDTH-1:0]  rs_addr,
    output logic [NUM_READ*XLEN-1:0]                  rs_data,
    output logic [NUM_READ-1:0]                       rs_ready,
    input  logic [NUM_WRITE-1:0]                      wb_wen,
    input  logic [NUM_WRITE*REGISTER_INDEX_WIDTH-1:0] wb_addr,
    input  logic [NUM_WRITE*XLEN-1:0]                 wb_data,
    input  logic                                      issue_valid,
    input  reg_idx_t                                  issue_rd,
    output logic                                      issue_ready,
    output logic [BUSY_COUNT_WIDTH-1:0]               busy_count
);

    localparam int IW = REGISTER_INDEX_WIDTH;

    logic [XLEN-1:0] regs [REGISTER_COUNT];
    reg_idx_t        ra;
    logic [XLEN-1:0] rd;

    // Ascending port order means the last non-blocking write, i.e. the
    // highest port index, is the one that sticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < REGISTER_COUNT; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wb_wen[j] && wb_addr[j*IW +: IW] != X0) begin
                    regs[wb_addr[j*IW +: IW]] <= wb_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rs_data = '0;
        ra      = X0;
        rd      = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            ra = rs_addr[i*IW +: IW];
            rd = regs[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WRITE; j++) begin
                    if (wb_wen[j] && wb_addr[j*IW +: IW] == ra) begin
                        rd = wb_data[j*XLEN +: XLEN];
                    end
                end
            end
            if (ra == X0) begin
                rd = '0;
            end
            rs_data[i*XLEN +: XLEN] = rd;
        end
    end

    regfile_scoreboard #(
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE),
        .BYPASS    (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rs_addr     (rs_addr),
        .rs_ready    (rs_ready),
        .wb_wen      (wb_wen),
        .wb_addr     (wb_addr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .busy_count  (busy_count)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share every input, each with two read and two write ports.
module tb_regfile_mp;
    import riscv_pkg::*;

    localparam int XLEN = 32;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int IW   = REGISTER_INDEX_WIDTH;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NR*IW-1:0]              rs_addr = '0;
    logic [NW-1:0]                 wb_wen = '0;
    logic [NW*IW-1:0]              wb_addr = '0;
    logic [NW*XLEN-1:0]            wb_data = '0;
    logic                          issue_valid = 1'b0;
    reg_idx_t                      issue_rd = '0;

    logic [NR*XLEN-1:0]            rs_data_b, rs_data_n;
    logic [NR-1:0]                 rs_ready_b, rs_ready_n;
    logic                          issue_ready_b, issue_ready_n;
    logic [BUSY_COUNT_WIDTH-1:0]   busy_count_b, busy_count_n;

    int n_vec = 0;
    int n_err = 0;
    logic [XLEN-1:0] exp_q[$];

    regfile_mp #(.XLEN(XLEN), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_ready(rs_ready_b),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_b),
        .busy_count(busy_count_b)
    );

    regfile_mp #(.XLEN(XLEN), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_ready(rs_ready_n),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_n),
        .busy_count(busy_count_n)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        wb_wen      = '0;
        wb_addr     = '0;
        wb_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    task automatic set_read(input int port, input int addr);
        rs_addr[port*IW +: IW] = IW'(addr);
    endtask

    task automatic wr(input int port, input int addr, input logic [XLEN-1:0] data);
        wb_wen[port]               = 1'b1;
        wb_addr[port*IW +: IW]     = IW'(addr);
        wb_data[port*XLEN +: XLEN] = data;
    endtask

    task automatic issue(input int rd_idx);
        issue_valid = 1'b1;
        issue_rd    = IW'(rd_idx);
    endtask

    function automatic logic [XLEN-1:0] rdb(input int port);
        return rs_data_b[port*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rdn(input int port);
        return rs_data_n[port*XLEN +: XLEN];
    endfunction

    initial begin
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state: read x0 and x5
        set_read(0, 0);
        set_read(1, 5);
        settle();
        check("rst_x0_data", rdb(0), 0);
        check("rst_x5_data", rdb(1), 0);
        check("rst_ready_b", rs_ready_b, 2'b11);
        check("rst_ready_n", rs_ready_n, 2'b11);
        check("rst_issue_ready", issue_ready_b, 1);
        check("rst_busy_count", busy_count_b, 0);

        // Write x5 while reading it: bypass sees it now, no-bypass next cycle
        step();
        exp_q.push_back(32'hDEADBEEF);
        wr(0, 5, 32'hDEADBEEF);
        settle();
        check("byp_x5_same", rdb(1), exp_q[0]);
        check("nobyp_x5_same", rdn(1), 0);
        step();
        idle();
        settle();
        check("nobyp_x5_next", rdn(1), exp_q[0]);
        check("byp_x5_next", rdb(1), exp_q.pop_front());

        // Both ports write x7: highest port wins
        set_read(0, 7);
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        settle();
        check("prio_x7_bypass", rdb(0), 32'h22);
        step();
        idle();
        settle();
        check("prio_x7_array_b", rdb(0), 32'h22);
        check("prio_x7_array_n", rdn(0), 32'h22);

        // Issue x3 then observe the scoreboard
        set_read(0, 3);
        issue(3);
        settle();
        check("iss3_ready", issue_ready_b, 1);
        step();
        settle();
        check("iss3_count", busy_count_b, 1);
        check("iss3_rs_ready", rs_ready_b[0], 0);
        check("iss3_waw_stall", issue_ready_b, 0);
        check("iss3_waw_stall_n", issue_ready_n, 0);
        step();
        check("iss3_stall_hold", busy_count_b, 1);
        issue_valid = 1'b0;
        wr(0, 3, 32'h33);
        settle();
        check("wr3_issue_ready", issue_ready_b, 1);
        check("wr3_rs_ready_b", rs_ready_b[0], 1);
        check("wr3_rs_ready_n", rs_ready_n[0], 0);
        step();
        idle();
        settle();
        check("wr3_count", busy_count_b, 0);
        check("wr3_rs_ready_next_n", rs_ready_n[0], 1);
        check("wr3_data", rdn(0), 32'h33);

        // Issue and write x9 together while busy: set wins
        set_read(0, 9);
        issue(9);
        step();
        settle();
        check("iss9_count", busy_count_b, 1);
        issue(9);
        wr(1, 9, 32'h99);
        settle();
        check("iss9_wr_ready", issue_ready_b, 1);
        step();
        idle();
        settle();
        check("iss9_still_busy", rs_ready_b[0], 0);
        check("iss9_count_same", busy_count_b, 1);

        // Issue to x0 is a no-op on the scoreboard
        issue(0);
        settle();
        check("iss0_ready", issue_ready_b, 1);
        step();
        idle();
        settle();
        check("iss0_count", busy_count_b, 1);

        // Fill x1..x4, then reset with a simultaneous write and issue
        for (int r = 1; r <= 4; r++) begin
            issue(r);
            step();
        end
        idle();
        settle();
        check("fill_count_b", busy_count_b, 5);
        check("fill_count_n", busy_count_n, 5);
        rst = 1'b1;
        wr(0, 2, 32'hAB);
        issue(5);
        step();
        rst = 1'b0;
        idle();
        set_read(0, 2);
        set_read(1, 7);
        settle();
        check("mid_rst_count", busy_count_b, 0);
        check("mid_rst_x2", rdb(0), 0);
        check("mid_rst_x7", rdb(1), 0);
        check("mid_rst_ready", rs_ready_b, 2'b11);
        set_read(1, 5);
        settle();
        check("mid_rst_x5", rdn(1), 0);

        // Write to x0 is ignored
        set_read(0, 0);
        wr(1, 0, 32'hFF);
        settle();
        check("x0_wr_same", rdb(0), 0);
        check("x0_wr_ready", rs_ready_b[0], 1);
        step();
        idle();
        settle();
        check("x0_wr_next", rdn(0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
